// File: rtl/seg7_pkg.sv
// Shared constants, register map and scan-state encoding for the 7-segment scan controller.
package seg7_pkg;

   localparam int unsigned REG_W      = 32;
   localparam int unsigned STRB_W     = REG_W / 8;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned CNT_W      = 16;

   localparam logic [3:0] OFFS_CTRL     = 4'h0;
   localparam logic [3:0] OFFS_DATA     = 4'h4;
   localparam logic [3:0] OFFS_PRESCALE = 4'h8;
   localparam logic [3:0] OFFS_DEADTIME = 4'hC;

   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_SEG_INV   = 1;
   localparam int unsigned CTRL_BLANK_LSB = 8;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   // Byte-lane merge of a write into an existing register value.
   function automatic logic [REG_W-1:0] apply_strb(input logic [REG_W-1:0]  cur,
                                                   input logic [REG_W-1:0]  wdata,
                                                   input logic [STRB_W-1:0] strb);
      logic [REG_W-1:0] res;
      res = cur;
      for (int b = 0; b < int'(STRB_W); b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high segment pattern, bit0 = segment a.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       hex,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = '0;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = '0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// AXI4-Lite register block driving a 4-digit multiplexed 7-segment display scanner.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                          S_AXI_AWPROT,
   input  logic                                S_AXI_AWVALID,
   output logic                                S_AXI_AWREADY,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                                S_AXI_WVALID,
   output logic                                S_AXI_WREADY,
   output logic [1:0]                          S_AXI_BRESP,
   output logic                                S_AXI_BVALID,
   input  logic                                S_AXI_BREADY,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                          S_AXI_ARPROT,
   input  logic                                S_AXI_ARVALID,
   output logic                                S_AXI_ARREADY,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                          S_AXI_RRESP,
   output logic                                S_AXI_RVALID,
   input  logic                                S_AXI_RREADY,
   output logic [SEG_W-1:0]                    seg,
   output logic                                dp,
   output logic [NUM_DIGITS-1:0]               an,
   output logic                                frame
);

   logic [REG_W-1:0] ctrl_q, data_q, prescale_q, deadtime_q, rdata_q, rd_mux;
   logic             aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
   logic             wr_fire, rd_fire;

   assign wr_fire = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire = ar_ready_q & S_AXI_ARVALID;

   // Write channel: single-cycle AW/W ready once both valids are present, then B response.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_ready_q <= 1'b0;
         b_valid_q  <= 1'b0;
      end else begin
         aw_ready_q <= !aw_ready_q && !b_valid_q && S_AXI_AWVALID && S_AXI_WVALID;
         if (wr_fire)           b_valid_q <= 1'b1;
         else if (S_AXI_BREADY) b_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ctrl_q     <= '0;
         data_q     <= '0;
         prescale_q <= '0;
         deadtime_q <= '0;
      end else if (wr_fire) begin
         case ({S_AXI_AWADDR[3:2], 2'b00})
            OFFS_CTRL:     ctrl_q     <= apply_strb(ctrl_q,     S_AXI_WDATA, S_AXI_WSTRB);
            OFFS_DATA:     data_q     <= apply_strb(data_q,     S_AXI_WDATA, S_AXI_WSTRB);
            OFFS_PRESCALE: prescale_q <= apply_strb(prescale_q, S_AXI_WDATA, S_AXI_WSTRB);
            default:       deadtime_q <= apply_strb(deadtime_q, S_AXI_WDATA, S_AXI_WSTRB);
         endcase
      end
   end

   always_comb begin
      case ({S_AXI_ARADDR[3:2], 2'b00})
         OFFS_CTRL:     rd_mux = ctrl_q;
         OFFS_DATA:     rd_mux = data_q;
         OFFS_PRESCALE: rd_mux = prescale_q;
         default:       rd_mux = deadtime_q;
      endcase
   end

   // Read channel: data captured at the AR handshake and held until RREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         ar_ready_q <= !ar_ready_q && !r_valid_q && S_AXI_ARVALID;
         if (rd_fire) begin
            r_valid_q <= 1'b1;
            rdata_q   <= rd_mux;
         end else if (S_AXI_RREADY) begin
            r_valid_q <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = aw_ready_q;
   assign S_AXI_WREADY  = aw_ready_q;
   assign S_AXI_BVALID  = b_valid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = ar_ready_q;
   assign S_AXI_RVALID  = r_valid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   // Scan FSM
   scan_state_t      state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_d, en, seg_inv;
   logic [3:0]       blank, dp_bits, nibble;
   logic [SEG_W-1:0] seg_raw, seg_d;
   logic             dp_d;
   logic [NUM_DIGITS-1:0] an_d;

   assign en      = ctrl_q[CTRL_EN];
   assign seg_inv = ctrl_q[CTRL_SEG_INV];
   assign blank   = ctrl_q[CTRL_BLANK_LSB +: 4];
   assign dp_bits = data_q[19:16];

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= ST_OFF;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Dwell ends on >= so a PRESCALE lowered mid-dwell cannot strand the counter.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      case (state_q)
         ST_OFF: begin
            idx_d = '0;
            cnt_d = '0;
            if (en) state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (cnt_q >= prescale_q[CNT_W-1:0]) begin
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
               frame_d = (idx_q == 2'd3);
               state_d = (deadtime_q[7:0] == 8'd0) ? ST_SHOW : ST_GAP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_GAP: begin
            if ((cnt_q + 16'd1) >= {8'd0, deadtime_q[7:0]}) begin
               cnt_d   = '0;
               state_d = ST_SHOW;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_OFF;
      endcase
      if (!en) begin
         state_d = ST_OFF;
         idx_d   = '0;
         cnt_d   = '0;
         frame_d = 1'b0;
      end
   end

   // Outputs follow the next state so they line up with the registered FSM state.
   assign nibble = 4'(data_q[15:0] >> {idx_d, 2'b00});

   seg7_decode u_decode (
      .hex (nibble),
      .seg (seg_raw)
   );

   always_comb begin
      an_d  = '0;
      seg_d = {SEG_W{seg_inv}};
      dp_d  = seg_inv;
      if (state_d == ST_SHOW) begin
         seg_d = seg_raw ^ {SEG_W{seg_inv}};
         dp_d  = dp_bits[idx_d] ^ seg_inv;
         if (!blank[idx_d]) an_d = 4'b0001 << idx_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         seg   <= '0;
         dp    <= 1'b0;
         an    <= '0;
         frame <= 1'b0;
      end else begin
         seg   <= seg_d;
         dp    <= dp_d;
         an    <= an_d;
         frame <= frame_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                          ctrl_q[31:12], ctrl_q[7:2], data_q[31:20], prescale_q[31:16],
                          deadtime_q[31:8]};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: register map over AXI4-Lite and scan timing.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        areset;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [6:0]  seg;
   logic        dp, frame;
   logic [3:0]  an;

   int tests  = 0;
   int failed = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   seg7_scan_ctrl dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .seg(seg), .dp(dp), .an(an), .frame(frame)
   );

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // Expected {frame, dp, an, seg} at cycle k after the scan starts (k=0 is digit 0, first cycle).
   function automatic logic [12:0] scan_exp(input int k, input int p, input int d,
                                            input logic [31:0] data, input logic [3:0] mask,
                                            input logic inv);
      int l, pos, dg;
      logic show, f, dpv;
      logic [3:0] a;
      logic [6:0] s;
      l    = p + 1 + d;
      pos  = k % (4 * l);
      dg   = pos / l;
      show = (pos % l) < (p + 1);
      a    = (show && !mask[dg]) ? 4'(1 << dg) : 4'b0000;
      s    = show ? (ref_seg(data[dg*4 +: 4]) ^ {7{inv}}) : {7{inv}};
      dpv  = show ? (data[16 + dg] ^ inv) : inv;
      f    = (k > 0) && (pos == ((3 * l + p + 1) % (4 * l)));
      return {f, dpv, a, s};
   endfunction

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
      @(posedge clk);
      #1 awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("bvalid", {31'd0, bvalid}, 32'd1);
      check("bresp", {30'd0, bresp}, 32'd0);
      check("awready_pulse", {31'd0, awready}, 32'd0);
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clear", {31'd0, bvalid}, 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
      int n;
      logic [31:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      araddr = addr; arvalid = 1'b1; rready = 1'b0;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      check("arready", {31'd0, arready}, 32'd1);
      @(posedge clk);
      #1 arvalid = 1'b0;
      @(negedge clk);
      check("rvalid", {31'd0, rvalid}, 32'd1);
      e = 32'hx;
      if (rvalid) begin
         if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL rd_queue: got data 0x%0h expected none queued", rdata);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("rdata@%0h", addr), rdata, e);
         end
      end
      check("rresp", {30'd0, rresp}, 32'd0);
      @(negedge clk);
      if (!$isunknown(e)) check("rdata_hold", rdata, e);
      check("rvalid_hold", {31'd0, rvalid}, 32'd1);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_clear", {31'd0, rvalid}, 32'd0);
   endtask

   task automatic check_scan(input int n, input int p, input int d, input logic [31:0] data,
                             input logic [3:0] mask, input logic inv);
      for (int k = 0; k < n; k++) begin
         check($sformatf("scan_k%0d", k), {19'd0, frame, dp, an, seg},
               {19'd0, scan_exp(k, p, d, data, mask, inv)});
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
      vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
      vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
      vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
      vecs[4] = '{4'h4, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD};
      vecs[5] = '{4'hC, 32'hFFFF_FFFF, 4'h8, 32'hFF00_0004};
      vecs[6] = '{4'h8, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
      vecs[7] = '{4'h0, 32'h1234_5678, 4'h2, 32'h0000_5601};

      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_disp", {19'd0, frame, dp, an, seg}, 32'd0);
      check("rst_axi", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
      areset = 1'b0;

      foreach (vecs[i]) begin
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         axi_read(vecs[i].addr, vecs[i].exp);
      end

      // Basic scan, no dead time
      @(negedge clk); areset = 1'b1; @(negedge clk); areset = 1'b0;
      axi_write(4'h4, 32'h0000_4321, 4'hF);
      axi_write(4'h8, 32'd3, 4'hF);
      axi_write(4'hC, 32'd0, 4'hF);
      check("off_an", {28'd0, an}, 32'd0);
      axi_write(4'h0, 32'd1, 4'hF);
      check_scan(40, 3, 0, 32'h0000_4321, 4'b0000, 1'b0);

      // Dead time of 2 cycles between digits
      axi_write(4'h0, 32'd0, 4'hF);
      axi_write(4'hC, 32'd2, 4'hF);
      check("off_an2", {28'd0, an}, 32'd0);
      axi_write(4'h0, 32'd1, 4'hF);
      check_scan(60, 3, 2, 32'h0000_4321, 4'b0000, 1'b0);

      // Digit 1 blanked, inverted segments, dp bits on digits 0 and 2
      axi_write(4'h0, 32'd0, 4'hF);
      axi_write(4'h4, 32'h0005_4321, 4'hF);
      axi_write(4'hC, 32'd0, 4'hF);
      axi_write(4'h0, 32'h0000_0203, 4'hF);
      check_scan(40, 3, 0, 32'h0005_4321, 4'b0010, 1'b1);

      // Clear EN mid-dwell of digit 2, then restart from digit 0
      axi_write(4'h0, 32'd0, 4'hF);
      axi_write(4'h4, 32'h0000_4321, 4'hF);
      axi_write(4'h0, 32'd1, 4'hF);
      check_scan(7, 3, 0, 32'h0000_4321, 4'b0000, 1'b0);
      axi_write(4'h0, 32'd0, 4'hF);
      check("en_clr_disp", {19'd0, frame, dp, an, seg}, 32'd0);
      axi_write(4'h0, 32'd1, 4'hF);
      check_scan(12, 3, 0, 32'h0000_4321, 4'b0000, 1'b0);

      // Reset with BVALID pending and AW/W still asserted
      axi_write(4'h8, 32'd1, 4'hF);
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'h0000_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      check("rst_case_awready", {31'd0, awready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("rst_case_bvalid", {31'd0, bvalid}, 32'd1);
      areset = 1'b1;
      @(negedge clk);
      check("rst_case_bdrop", {29'd0, bvalid, awready, wready}, 32'd0);
      check("rst_case_disp", {19'd0, frame, dp, an, seg}, 32'd0);
      areset = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      axi_read(4'h0, 32'd0);
      axi_read(4'h4, 32'd0);
      axi_read(4'h8, 32'd0);
      axi_read(4'hC, 32'd0);
      check("rst_case_off", {28'd0, an}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 C_S00_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 supported.
REQ-002 C_S00_AXI_ADDR_WIDTH, 4, byte address width; 4 word registers at offsets 0x0/0x4/0x8/0xC.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 S_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite slave channels (AWADDR, AWPROT, AWVALID/READY, WDATA, WSTRB, WVALID/READY, BRESP, BVALID/READY, ARADDR, ARPROT, ARVALID/READY, RDATA, RRESP, RVALID/READY).
REQ-006 seg  out  7  segment cathodes a..g, bit0=a.
REQ-007 dp  out  1  decimal point.
REQ-008 an  out  4  digit anodes, one-hot active-high.
REQ-009 frame  out  1  one-cycle pulse when digit 3 dwell ends.

Function
REQ-010 Registers SHALL be 32-bit read/write with full readback of every written bit (WSTRB honoured per byte): R0 CTRL, R1 DATA, R2 PRESCALE, R3 DEADTIME.
REQ-011 Field map: CTRL[0]=EN, CTRL[1]=SEG_INV, CTRL[11:8]=blank mask (1 = digit dark); DATA[4k+3:4k]=hex nibble of digit k, DATA[16+k]=dp of digit k; PRESCALE[15:0]=dwell-1; DEADTIME[7:0]=gap cycles.
REQ-012 Write: slave waits until AWVALID and WVALID both high, asserts AWREADY and WREADY together for exactly one cycle, updates register on that edge, asserts BVALID next cycle, holds until BREADY; no new write accepted while BVALID high.
REQ-013 Read: ARREADY one-cycle pulse, RVALID next cycle with RDATA, held stable until RREADY; no new read accepted while RVALID high.
REQ-014 BRESP and RRESP SHALL always be OKAY (2'b00).
REQ-015 Write and read may complete in the same cycle independently.
REQ-016 Scan FSM states: OFF, SHOW, GAP.
REQ-017 OFF: an=0, digit index=0, dwell counter=0; EN=1 -> SHOW on next edge.
REQ-018 SHOW: an=one-hot(index) unless masked (then 0); seg/dp from hex decode of current nibble, live from DATA; lasts PRESCALE[15:0]+1 cycles, terminated when counter >= PRESCALE (covers PRESCALE lowered mid-dwell).
REQ-019 SHOW end: DEADTIME=0 -> SHOW for index+1; else GAP; index wraps 3->0; frame pulses on the edge that leaves index 3.
REQ-020 GAP: an=0, seg/dp=inactive; lasts DEADTIME[7:0] cycles, then SHOW for next index.
REQ-021 EN=0 in any state -> OFF on next edge, index and counters cleared.
REQ-022 SEG_INV=1 inverts seg and dp only, never an; inactive seg level = SEG_INV.
REQ-023 All outputs SHALL be registered; a DATA write is visible on seg one cycle after the write handshake edge.
REQ-024 Hex decode SHALL cover 0-F (standard patterns, A/b/C/d/E/F).

Reset
REQ-025 ARESET=1: all registers 0, FSM OFF, seg=0, dp=0, an=0, frame=0, all READY/VALID low.
REQ-026 ARESET mid-transaction SHALL abandon the transaction with no register update; mid-scan returns to OFF.

Structure
REQ-027 Package seg7_pkg holds register offsets, CTRL bit positions, FSM state enum, digit count constant (4).
REQ-028 Sub-module seg7_decode: combinational 4-bit hex to 7-bit segments; one instance.
REQ-029 AXI slave logic and scan FSM in seg7_scan_ctrl; target 150-300 lines total.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to offsets 0x0..0xC, read back -> 0x1,0x2,0x3,0x4, RESP=OKAY.
REQ-031 DATA=0x0000_4321, PRESCALE=3, DEADTIME=0, CTRL=1 -> an 0001,0010,0100,1000 each 4 cycles, seg = decode 1,2,3,4, frame every 16 cycles.
REQ-032 DEADTIME=2 -> 2-cycle an=0 gap between digits; frame period 24 cycles with PRESCALE=3.
REQ-033 CTRL=0x0000_0203 (mask digit1, SEG_INV) -> an stays 0 during digit1 slot; seg inverted; an polarity unchanged.
REQ-034 Clear EN mid-dwell of digit 2 -> an=0 next cycle; re-enable -> scan restarts at digit 0.
REQ-035 ARESET pulsed with BVALID high and AWVALID/WVALID held -> BVALID drops, registers read 0 afterward.
